// File: rtl/slot_pkg.sv
// Shared constants, types and the saturating credit update for the slot-machine controller.
package slot_pkg;

  localparam int unsigned CREDIT_W   = 8;
  localparam int unsigned REEL_W     = 3;
  localparam int unsigned BET        = 1;
  localparam int unsigned PAY_PAIR   = 2;
  localparam int unsigned PAY_TRIPLE = 10;
  localparam int unsigned PAY_JACK   = 50;
  localparam int unsigned JACK_SYM   = 7;
  localparam int unsigned TIMEOUT    = 15;
  localparam int unsigned TIMER_W    = 4;

  typedef logic [CREDIT_W-1:0] credit_t;
  typedef logic [REEL_W-1:0]   reel_t;
  typedef logic [TIMER_W-1:0]  timer_t;

  typedef enum logic [2:0] {
    StIdle,
    StSpin,
    StEval,
    StPay,
    StRelease
  } state_e;

  // base + coin + add - sub, clamped at the register maximum. Callers only subtract
  // when base >= sub, so the result never goes negative.
  function automatic credit_t sat_update(credit_t base, logic coin, credit_t sub, credit_t add);
    logic [CREDIT_W+1:0] sum;
    sum = {2'b00, base} + {{(CREDIT_W + 1){1'b0}}, coin} + {2'b00, add} - {2'b00, sub};
    if (sum > {2'b00, {CREDIT_W{1'b1}}}) begin
      return '1;
    end
    return sum[CREDIT_W-1:0];
  endfunction

endpackage

// File: rtl/slot_game_ctrl_if.sv
// Bundle of the button/counter inputs and status outputs of the slot game controller.
interface slot_game_ctrl_if;
  import slot_pkg::*;

  logic    coin;
  logic    spin;
  logic    compute;
  logic    hold;
  reel_t   reel0;
  reel_t   reel1;
  reel_t   reel2;
  logic    run_game;
  credit_t credits;
  logic    win;
  credit_t payout;
  logic    fault;
  logic    busy;

  modport master (
    output coin, spin, compute, hold, reel0, reel1, reel2,
    input  run_game, credits, win, payout, fault, busy
  );

  modport slave (
    input  coin, spin, compute, hold, reel0, reel1, reel2,
    output run_game, credits, win, payout, fault, busy
  );

endinterface

// File: rtl/slot_payout_calc.sv
// Combinational payout table: three of a kind (jackpot symbol pays most), any pair, or nothing.
module slot_payout_calc
  import slot_pkg::*;
(
  input  reel_t   reel0,
  input  reel_t   reel1,
  input  reel_t   reel2,
  output credit_t payout
);

  always_comb begin
    payout = '0;
    if (reel0 == reel1 && reel1 == reel2) begin
      payout = (reel0 == reel_t'(JACK_SYM)) ? credit_t'(PAY_JACK) : credit_t'(PAY_TRIPLE);
    end else if (reel0 == reel1 || reel1 == reel2 || reel0 == reel2) begin
      payout = credit_t'(PAY_PAIR);
    end
  end

endmodule

// File: rtl/slot_game_ctrl.sv
// Play sequencer: debit on spin, run the reel counter, evaluate and credit payout, then release.
module slot_game_ctrl
  import slot_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  slot_game_ctrl_if.slave bus
);

  state_e  state_q, state_d;
  credit_t credits_q, credits_d;
  credit_t payout_q, payout_d;
  credit_t calc_payout;
  credit_t credit_sub, credit_add;
  reel_t   reel0_q, reel0_d;
  reel_t   reel1_q, reel1_d;
  reel_t   reel2_q, reel2_d;
  timer_t  timer_q, timer_d;
  logic    run_game_q, run_game_d;
  logic    win_q, win_d;
  logic    fault_q, fault_d;
  logic    can_spin;

  // Eligibility looks at the registered balance only; a same-cycle coin does not count.
  assign can_spin = (credits_q >= credit_t'(BET));

  slot_payout_calc u_payout_calc (
    .reel0  (reel0_q),
    .reel1  (reel1_q),
    .reel2  (reel2_q),
    .payout (calc_payout)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    fault_d    = fault_q;
    payout_d   = payout_q;
    reel0_d    = reel0_q;
    reel1_d    = reel1_q;
    reel2_d    = reel2_q;
    credit_sub = '0;
    credit_add = '0;
    win_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.spin && can_spin) begin
          credit_sub = credit_t'(BET);
          timer_d    = '0;
          state_d    = StSpin;
        end
      end
      StSpin: begin
        if (bus.compute) begin
          reel0_d = bus.reel0;
          reel1_d = bus.reel1;
          reel2_d = bus.reel2;
          state_d = StEval;
        end else if (timer_q == timer_t'(TIMEOUT)) begin
          // Counter never settled: give the bet back and flag it permanently.
          credit_add = credit_t'(BET);
          fault_d    = 1'b1;
          state_d    = StRelease;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StEval: begin
        payout_d = calc_payout;
        win_d    = (calc_payout != '0);
        state_d  = StPay;
      end
      StPay: begin
        credit_add = payout_q;
        state_d    = StRelease;
      end
      StRelease: begin
        if (!bus.hold) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    credits_d  = sat_update(credits_q, bus.coin, credit_sub, credit_add);
    run_game_d = (state_d == StSpin) || (state_d == StEval) || (state_d == StPay);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      credits_q  <= '0;
      payout_q   <= '0;
      reel0_q    <= '0;
      reel1_q    <= '0;
      reel2_q    <= '0;
      timer_q    <= '0;
      run_game_q <= 1'b0;
      win_q      <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      credits_q  <= credits_d;
      payout_q   <= payout_d;
      reel0_q    <= reel0_d;
      reel1_q    <= reel1_d;
      reel2_q    <= reel2_d;
      timer_q    <= timer_d;
      run_game_q <= run_game_d;
      win_q      <= win_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.run_game = run_game_q;
  assign bus.credits  = credits_q;
  assign bus.win      = win_q;
  assign bus.payout   = payout_q;
  assign bus.fault    = fault_q;
  assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_slot_game_ctrl.sv
// Directed bench for slot_game_ctrl: a table of plays plus hand sequences for the corner cases.
module tb_slot_game_ctrl;
  import slot_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  slot_game_ctrl_if bus ();

  slot_game_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int r0;
    int r1;
    int r2;
    int delay;
    int pay;
    bit coin_spin;
    bit coin_pay;
    bit spin_late;
  } vec_t;

  vec_t vecs[9];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   exp_cred = 0;
  int   cur_id = -1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got %0d, want %0d", name, cur_id, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic coin_pulse();
    bus.coin = 1'b1;
    step();
    bus.coin = 1'b0;
  endtask

  // One complete play from IDLE; exp_cred is the bench's own credit model.
  task automatic play(input vec_t v);
    bus.reel0 = reel_t'(v.r0);
    bus.reel1 = reel_t'(v.r1);
    bus.reel2 = reel_t'(v.r2);
    bus.spin  = 1'b1;
    bus.coin  = v.coin_spin;
    step();
    bus.spin = 1'b0;
    bus.coin = 1'b0;
    exp_cred = exp_cred - 1 + int'(v.coin_spin);
    chk("spin_run_game", bus.run_game, 1);
    chk("spin_debit", bus.credits, exp_cred);
    bus.hold = 1'b1;
    repeat (v.delay) step();
    chk("spin_wait_run_game", bus.run_game, 1);
    bus.compute = 1'b1;
    step();
    bus.compute = 1'b0;
    chk("eval_run_game", bus.run_game, 1);
    chk("eval_win", bus.win, 0);
    step();
    chk("pay_run_game", bus.run_game, 1);
    chk("pay_win", bus.win, int'(v.pay != 0));
    chk("pay_payout", bus.payout, v.pay);
    chk("pay_credits", bus.credits, exp_cred);
    bus.coin = v.coin_pay;
    bus.spin = v.spin_late;
    step();
    bus.coin = 1'b0;
    bus.spin = 1'b0;
    exp_cred = sat(exp_cred + v.pay + int'(v.coin_pay));
    chk("release_run_game", bus.run_game, 0);
    chk("release_win", bus.win, 0);
    chk("release_credits", bus.credits, exp_cred);
    bus.spin = v.spin_late;
    repeat (2) step();
    bus.spin = 1'b0;
    chk("release_held", bus.busy, 1);
    chk("release_held_credits", bus.credits, exp_cred);
    bus.hold = 1'b0;
    step();
    chk("idle_busy", bus.busy, 0);
    chk("idle_run_game", bus.run_game, 0);
    chk("idle_payout_held", bus.payout, v.pay);
    chk("idle_credits", bus.credits, exp_cred);
  endtask

  initial begin
    int   n;
    int   c0;
    vec_t sv;

    bus.coin = 1'b0;
    bus.spin = 1'b0;
    bus.compute = 1'b0;
    bus.hold = 1'b0;
    bus.reel0 = '0;
    bus.reel1 = '0;
    bus.reel2 = '0;

    //            r0 r1 r2 dly pay cs cp sl
    vecs[0] = '{1, 2, 3, 5, 0,  0, 0, 0};
    vecs[1] = '{6, 5, 4, 2, 0,  0, 0, 0};
    vecs[2] = '{7, 7, 7, 0, 50, 0, 0, 0};
    vecs[3] = '{5, 5, 2, 1, 2,  0, 0, 1};
    vecs[4] = '{3, 6, 3, 4, 2,  1, 0, 0};
    vecs[5] = '{0, 1, 1, 2, 2,  0, 1, 0};
    vecs[6] = '{0, 0, 0, 1, 10, 0, 0, 0};
    vecs[7] = '{7, 7, 1, 0, 2,  0, 0, 0};
    vecs[8] = '{4, 4, 4, 3, 10, 0, 0, 0};

    // Reset values
    #12;
    chk("rst_credits", bus.credits, 0);
    chk("rst_payout", bus.payout, 0);
    chk("rst_run_game", bus.run_game, 0);
    chk("rst_win", bus.win, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_busy", bus.busy, 0);
    step();
    rst_n = 1'b1;
    step();

    // Spin with no credit is ignored; a coin in the same cycle does not enable it
    bus.spin = 1'b1;
    step();
    bus.spin = 1'b0;
    chk("nocredit_busy", bus.busy, 0);
    chk("nocredit_run_game", bus.run_game, 0);
    bus.spin = 1'b1;
    bus.coin = 1'b1;
    step();
    bus.spin = 1'b0;
    bus.coin = 1'b0;
    chk("coinspin_credits", bus.credits, 1);
    step();
    chk("coinspin_busy", bus.busy, 0);
    chk("coinspin_run_game", bus.run_game, 0);
    coin_pulse();
    coin_pulse();
    exp_cred = 3;
    chk("three_coins", bus.credits, exp_cred);

    for (int i = 0; i < 9; i++) begin
      cur_id = i;
      play(vecs[i]);
    end
    cur_id = -1;

    // Counter never settles: refund, sticky fault, release on hold low
    c0 = exp_cred;
    bus.spin = 1'b1;
    step();
    bus.spin = 1'b0;
    bus.hold = 1'b1;
    n = 0;
    while (!bus.fault && n < 40) begin
      step();
      n++;
    end
    chk("timeout_fault", bus.fault, 1);
    chk("timeout_cycles", int'(n >= 15 && n <= 16), 1);
    chk("timeout_refund", bus.credits, c0);
    chk("timeout_run_game", bus.run_game, 0);
    chk("timeout_busy", bus.busy, 1);
    repeat (3) step();
    chk("timeout_hold_busy", bus.busy, 1);
    bus.hold = 1'b0;
    step();
    chk("timeout_idle", bus.busy, 0);
    chk("timeout_fault_sticky", bus.fault, 1);

    // Fill to the ceiling, then a winning play with a coin in PAY must clamp at 255
    while (exp_cred < 255) begin
      coin_pulse();
      exp_cred++;
    end
    coin_pulse();
    chk("sat_coin", bus.credits, 255);
    cur_id = 9;
    sv = '{4, 4, 4, 2, 10, 0, 1, 0};
    play(sv);
    chk("sat_after_pay", bus.credits, 255);
    cur_id = -1;

    // Reset mid-SPIN drops outputs without waiting for a clock edge
    bus.spin = 1'b1;
    step();
    bus.spin = 1'b0;
    bus.hold = 1'b1;
    step();
    chk("midspin_run_game", bus.run_game, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_run_game", bus.run_game, 0);
    chk("async_credits", bus.credits, 0);
    chk("async_busy", bus.busy, 0);
    chk("async_fault", bus.fault, 0);
    bus.hold = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_credits", bus.credits, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
